mux_tree_ccff_param: RTL and testbench

//  Parametrised routing mux: MUX_SIZE:1 tree of 2:1 basis stages whose select bits sit in an

---
 rtl/mux_tree_ccff_param.sv | 83 ++++++++
 tb/tb_mux_tree_ccff_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_ccff_param.sv
// MUX_SIZE:1 tree of 2:1 stages whose select word is loaded serially into a shadow
// register and committed to an active copy. Optional MUX_TREE_OUT_REG_EN registers out.
module mux_tree_ccff_param #(
  parameter int MUX_SIZE = 4,
  localparam int SEL_W = $clog2(MUX_SIZE)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  output logic                ccff_tail,
  input  logic                commit,
  input  logic [MUX_SIZE-1:0] in,
  output logic                out,
  output logic [SEL_W-1:0]    sel_idx,
  output logic                cfg_loaded,
  output logic                cfg_err
);

  localparam int PAD   = 1 << SEL_W;
  localparam int CNT_W = $clog2(SEL_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SEL_W-1:0] shadow;
  logic [SEL_W-1:0] shadow_shifted;
  logic [SEL_W-1:0] active;
  logic [CNT_W-1:0] bit_cnt;
  logic [PAD-1:0]   lvl [0:SEL_W];
  logic             tree_out;

  assign ccff_tail  = shadow[SEL_W-1];
  assign cfg_loaded = (bit_cnt == CNT_FULL);
  assign sel_idx    = ~active;

  // Shift built with a shift operator so a single-bit chain (MUX_SIZE=2) stays legal.
  always_comb begin
    shadow_shifted    = shadow << 1;
    shadow_shifted[0] = ccff_head;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow  <= '1;
      active  <= '1;
      bit_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (commit) begin
        if (cfg_loaded) active  <= shadow;
        else            cfg_err <= 1'b1;
      end
      if (ccff_en) shadow <= shadow_shifted;
      // A commit restarts the count; a shift in the same cycle is the first bit of the next load.
      if (commit && cfg_loaded)
        bit_cnt <= ccff_en ? CNT_ONE : '0;
      else if (ccff_en && !cfg_loaded)
        bit_cnt <= bit_cnt + CNT_ONE;
    end
  end

  // Leaf level is padded with zeros so out-of-range indices route a constant 0.
  always_comb begin
    for (int unsigned k = 0; k <= SEL_W; k++) lvl[k] = '0;
    lvl[0][MUX_SIZE-1:0] = in;
    for (int unsigned k = 0; k < SEL_W; k++) begin
      for (int unsigned j = 0; j < (PAD >> (k + 1)); j++) begin
        lvl[k+1][j] = active[k] ? lvl[k][2*j] : lvl[k][2*j+1];
      end
    end
    tree_out = lvl[SEL_W][0];
  end

`ifdef MUX_TREE_OUT_REG_EN
  always_ff @(posedge prog_clk) begin
    if (pReset) out <= 1'b0;
    else        out <= tree_out;
  end
`else
  always_comb out = tree_out;
`endif

endmodule

// File: tb/tb_mux_tree_ccff_param.sv
// Directed bench for mux_tree_ccff_param (MUX_SIZE 4 and 5) with a scoreboard queue.
module tb_mux_tree_ccff_param;

  logic prog_clk = 1'b0;
  logic pReset;
  logic head4, en4, commit4, tail4, out4, loaded4, err4;
  logic head5, en5, commit5, tail5, out5, loaded5, err5;
  logic [3:0] in4;
  logic [4:0] in5;
  logic [1:0] sel4;
  logic [2:0] sel5;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] expv;
  } sb_item_t;
  sb_item_t sb [$];

  always #5 prog_clk = ~prog_clk;

  mux_tree_ccff_param #(.MUX_SIZE(4)) u4 (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_head(head4), .ccff_en(en4),
    .ccff_tail(tail4), .commit(commit4), .in(in4), .out(out4),
    .sel_idx(sel4), .cfg_loaded(loaded4), .cfg_err(err4)
  );

  mux_tree_ccff_param #(.MUX_SIZE(5)) u5 (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_head(head5), .ccff_en(en5),
    .ccff_tail(tail5), .commit(commit5), .in(in5), .out(out5),
    .sel_idx(sel5), .cfg_loaded(loaded5), .cfg_err(err5)
  );

  function automatic logic ref_out(input logic [7:0] v, input int idx, input int n);
    return (idx < n) ? v[idx] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic settle();
`ifdef MUX_TREE_OUT_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    sb_item_t it;
    it.tag  = tag;
    it.expv = v;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [7:0] obs);
    sb_item_t it;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.expv) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.expv);
      end
    end
  endtask

  task automatic shift(input int u, input logic b);
    if (u == 4) begin head4 = b; en4 = 1'b1; end
    else        begin head5 = b; en5 = 1'b1; end
    tick();
    en4 = 1'b0;
    en5 = 1'b0;
  endtask

  task automatic do_commit(input int u);
    if (u == 4) commit4 = 1'b1;
    else        commit5 = 1'b1;
    tick();
    commit4 = 1'b0;
    commit5 = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
  endtask

  task automatic drive4(input string tag, input logic [3:0] v, input int idx);
    in4 = v;
    push(tag, {7'b0, ref_out({4'b0, v}, idx, 4)});
    settle();
    chk({7'b0, out4});
  endtask

  task automatic drive5(input string tag, input logic [4:0] v, input int idx);
    in5 = v;
    push(tag, {7'b0, ref_out({3'b0, v}, idx, 5)});
    settle();
    chk({7'b0, out5});
  endtask

  initial begin
    pReset = 1'b0;
    head4 = 1'b0; en4 = 1'b0; commit4 = 1'b0; in4 = 4'b0001;
    head5 = 1'b0; en5 = 1'b0; commit5 = 1'b0; in5 = 5'b00000;
    @(negedge prog_clk);

    // reset state
    do_reset();
    push("rst_sel", 8'd0);    chk({6'b0, sel4});
    push("rst_loaded", 8'd0); chk({7'b0, loaded4});
    push("rst_err", 8'd0);    chk({7'b0, err4});
    push("rst_tail", 8'd1);   chk({7'b0, tail4});
    drive4("rst_out", 4'b0001, 0);

    // load 0,1 -> shadow 01 -> index 2
    shift(4, 1'b0);
    push("load_partial", 8'd0); chk({7'b0, loaded4});
    shift(4, 1'b1);
    push("load_full", 8'd1);     chk({7'b0, loaded4});
    push("sel_before_commit", 8'd0); chk({6'b0, sel4});
    do_commit(4);
    push("sel_after_commit", 8'd2); chk({6'b0, sel4});
    push("loaded_drop", 8'd0);      chk({7'b0, loaded4});
    drive4("sel2_one", 4'b0100, 2);
    drive4("sel2_zero", 4'b1011, 2);

    // MUX_SIZE=5: 0,0,1 -> index 6 (out of range)
    shift(5, 1'b0); shift(5, 1'b0); shift(5, 1'b1);
    do_commit(5);
    push("m5_sel6", 8'd6); chk({5'b0, sel5});
    drive5("m5_oor", 5'b11111, 6);
    // 0,1,1 -> index 4, last valid input
    shift(5, 1'b0); shift(5, 1'b1); shift(5, 1'b1);
    do_commit(5);
    push("m5_sel4", 8'd4); chk({5'b0, sel5});
    drive5("m5_last_one", 5'b10000, 4);
    drive5("m5_last_zero", 5'b01111, 4);
    push("m5_err", 8'd0); chk({7'b0, err5});

    // premature commit then valid load
    shift(4, 1'b1);
    do_commit(4);
    push("early_err", 8'd1);     chk({7'b0, err4});
    push("early_sel_kept", 8'd2); chk({6'b0, sel4});
    shift(4, 1'b0);
    do_commit(4);
    push("reload_sel", 8'd1);  chk({6'b0, sel4});
    push("err_sticky", 8'd1);  chk({7'b0, err4});

    // commit and shift together: active gets 01, shadow becomes 10
    shift(4, 1'b0); shift(4, 1'b1);
    push("pre_tail", 8'd0); chk({7'b0, tail4});
    head4 = 1'b0; en4 = 1'b1; commit4 = 1'b1;
    tick();
    en4 = 1'b0; commit4 = 1'b0;
    push("cs_sel", 8'd2);     chk({6'b0, sel4});
    push("cs_tail", 8'd1);    chk({7'b0, tail4});
    push("cs_cnt1", 8'd0);    chk({7'b0, loaded4});
    shift(4, 1'b1);
    push("cs_cnt2", 8'd1);    chk({7'b0, loaded4});
    push("cs_tail2", 8'd0);   chk({7'b0, tail4});

    // reset clears sticky error and select
    do_reset();
    push("rst2_err", 8'd0); chk({7'b0, err4});
    push("rst2_sel", 8'd0); chk({6'b0, sel4});

    // saturating count: three shifts 1,0,1 -> shadow 01 -> index 2
    shift(4, 1'b1); shift(4, 1'b0); shift(4, 1'b1);
    push("sat_loaded", 8'd1); chk({7'b0, loaded4});
    do_commit(4);
    push("sat_sel", 8'd2); chk({6'b0, sel4});

    // reset mid-load discards partial shift
    shift(4, 1'b0);
    do_reset();
    push("midrst_tail", 8'd1); chk({7'b0, tail4});
    shift(4, 1'b1);
    do_commit(4);
    push("midrst_err", 8'd1); chk({7'b0, err4});
    push("midrst_sel", 8'd0); chk({6'b0, sel4});

`ifdef MUX_TREE_OUT_REG_EN
    do_reset();
    in4 = 4'b0000;
    tick();
    in4 = 4'b0001;
    #1;
    push("reg_stale", 8'd0); chk({7'b0, out4});
    tick();
    push("reg_follow", 8'd1); chk({7'b0, out4});
    head4 = 1'b0; en4 = 1'b1;
    tick();
    pReset = 1'b1;
    tick();
    en4 = 1'b0; pReset = 1'b0;
    push("reg_rst_out", 8'd0); chk({7'b0, out4});
    push("reg_rst_sel", 8'd0); chk({6'b0, sel4});
`else
    in4 = 4'b0000;
    #1;
    in4 = 4'b0001;
    #1;
    push("comb_follow", 8'd1); chk({7'b0, out4});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
